// File: rtl/cic_interpolator.sv
// 5-stage CIC interpolator: low-rate comb, zero-stuff, clk-rate integrators.
// Define CIC_INTERP_SATURATE_EN to clamp data_out instead of wrapping it.
module cic_interpolator #(
  parameter int DATA_WIDTH          = 12,
  parameter int REGISTER_WIDTH      = 64,
  parameter int INTERPOLATION_RATIO = 16,
  parameter int GAIN_WIDTH          = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [GAIN_WIDTH-1:0] gain,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sample_clk,
  output logic                  underrun
);

  localparam int N    = 5;
  localparam int DW   = DATA_WIDTH;
  localparam int RW   = REGISTER_WIDTH;
  localparam int CW   = $clog2(INTERPOLATION_RATIO);
  localparam int HEAD = RW - DW;
  localparam int SW   = $clog2(RW + 1);

  localparam logic [CW-1:0] CNT_LAST =
    CW'(INTERPOLATION_RATIO - 1);
  localparam logic [CW-1:0] CNT_HALF =
    CW'(INTERPOLATION_RATIO / 2);

`ifdef CIC_INTERP_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          load;
  logic          xfer;

  logic signed [RW-1:0] x;
  logic signed [RW-1:0] u;
  logic signed [RW-1:0] c  [N];
  logic signed [RW-1:0] cd [N];
  logic signed [RW-1:0] i  [N];

  logic [SW-1:0]        shamt;
  logic signed [RW-1:0] shifted;
  logic [HEAD:0]        top;
  logic                 ovf;
  logic [DW-1:0]        lim;

  assign cnt_nxt = cnt + CW'(1);
  // ready is registered from the counter, so it marks the load cycle
  assign load    = data_in_ready;
  assign xfer    = data_in_valid && data_in_ready;

  assign x = xfer ? {{HEAD{data_in[DW-1]}}, data_in} : '0;
  assign u = (cnt == '0) ? c[N-1] : '0;

  // Phase counter and the strobes registered from its next value
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt           <= '0;
      data_in_ready <= 1'b0;
      sample_clk    <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      data_in_ready <= (cnt_nxt == CNT_LAST);
      sample_clk    <= (cnt_nxt < CNT_HALF);
      underrun      <= load && !data_in_valid;
    end
  end

  // Comb section advances once per low-rate period
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < N; k++) begin
        c[k]  <= '0;
        cd[k] <= '0;
      end
    end else if (load) begin
      c[0]  <= x - cd[0];
      cd[0] <= x;
      for (int k = 1; k < N; k++) begin
        c[k]  <= c[k-1] - cd[k];
        cd[k] <= c[k-1];
      end
    end
  end

  // Integrator section runs at the clk rate on the zero-stuffed comb output
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < N; k++) begin
        i[k] <= '0;
      end
    end else begin
      i[0] <= i[0] + u;
      for (int k = 1; k < N; k++) begin
        i[k] <= i[k] + i[k-1];
      end
    end
  end

  // Shift amount shrinks as gain grows, floored at zero
  always_comb begin
    shamt = '0;
    if (32'(gain) <= 32'(HEAD)) begin
      shamt = SW'(HEAD - int'(gain));
    end
  end

  assign shifted = i[N-1] >>> shamt;
  assign top     = shifted[RW-1:DW-1];
  assign ovf     = !((&top) || !(|top));
  assign lim     = shifted[RW-1] ? {1'b1, {(DW-1){1'b0}}}
                                 : {1'b0, {(DW-1){1'b1}}};

  // Output either clamps or keeps the low bits of the scaled value
  always_comb begin
    data_out = shifted[DW-1:0];
    if (SAT && ovf) begin
      data_out = lim;
    end
  end

endmodule

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- 5-stage CIC interpolator (N=5, M=1): the transmit-side counterpart of the team's 5-stage CIC decimator.
- Accepts low-rate signed samples once every INTERPOLATION_RATIO clk cycles over a valid/ready handshake.
- Datapath: comb section at the low rate, zero-stuffing upsampler, integrator section at the clk rate.
- Emits one gain-scaled DATA_WIDTH sample per clk; feeds the DAC/modulator path of the SDR transmit chain.

Parameters:
- DATA_WIDTH, 12, input/output sample width (signed)
- REGISTER_WIDTH, 64, internal comb/integrator register width (signed, two's-complement wrap)
- INTERPOLATION_RATIO, 16, upsampling factor R; power of two, >= 4
- GAIN_WIDTH, 8, width of runtime gain (output shift control)

Ports:
- clk, input, 1, high-rate clock
- arst, input, 1, asynchronous active-high reset
- gain, input, GAIN_WIDTH, output scaling; larger value = less right shift
- data_in, input, DATA_WIDTH, signed low-rate sample
- data_in_valid, input, 1, data_in holds a sample
- data_in_ready, output, 1, block takes a sample this cycle
- data_out, output, DATA_WIDTH, signed high-rate sample, new value every clk
- sample_clk, output, 1, low-rate strobe, roughly 50 % duty, period R clk
- underrun, output, 1, one-cycle pulse: load slot passed with no valid sample

Behaviour:
- Interface: reset arst, asynchronous, active-high; clock clk.
- Reset values (any time, including mid-operation): all comb/integrator registers 0, phase counter 0, data_in_ready 0, underrun 0, sample_clk 0, data_out 0. The pipeline restarts cleanly; no partial state survives.
- Phase counter (clog2(R) bits):
  - Increments every clk and wraps R-1 -> 0.
- data_in_ready:
  - Registered; high exactly when counter == R-1, i.e. one cycle per R.
  - Does not depend on data_in_valid.
  - Transfer = data_in_valid && data_in_ready. Valid held in other cycles is ignored, not queued.
- Comb section:
  - Five registered stages, updated only on the load edge (end of the counter == R-1 cycle).
  - Stage input x = transfer ? sign-extended data_in : 0.
  - c1 <= x - x_d; x_d <= x; ck <= c(k-1) - ck_d; ck_d <= c(k-1), for k = 2..5.
- underrun:
  - Registered 1-cycle pulse on the load edge when data_in_valid = 0.
  - The comb stages still advance with zero input.
- Upsampler: integrator input u = (counter == 0) ? c5 : 0.
- Integrator section: five stages every clk, i1 <= i1 + u, ik <= ik + i(k-1). All arithmetic modulo 2^REGISTER_WIDTH; no saturation internally.
- Output scaling:
  - data_out = low DATA_WIDTH bits of (i5 >>> s), combinational from i5.
  - s = REGISTER_WIDTH - DATA_WIDTH - gain, clamped to 0 when gain > REGISTER_WIDTH - DATA_WIDTH.
- DC gain: R^(N-1) = 2^16 at defaults. gain = 36 gives unity at defaults (s = 16).
- sample_clk: registered; 1 for counter in [0, R/2-1], 0 otherwise. Low for the whole first cycle after reset.
- Latency: a sample accepted at load edge k reaches c5 after load edge k+4. It enters i1 at the end of the following counter == 0 cycle and reaches i5 four clk later.

Optional Feature:
- Macro: CIC_INTERP_SATURATE_EN.
- Defined: data_out saturates to +2^(DATA_WIDTH-1)-1 / -2^(DATA_WIDTH-1) when i5 >>> s lies outside the DATA_WIDTH signed range.
- Undefined: plain truncation (wrap) of the low DATA_WIDTH bits.
- Internal registers wrap in both builds.

Test Plan:
- Reset/handshake: release arst, hold data_in_valid=1 -> data_in_ready high exactly when counter==15, i.e. clk cycles 15, 31, 47 after release. sample_clk high for counter 0..7. underrun never pulses.
- DC unity: data_in=100 constant, gain=36 -> i5 settles to 100*65536; data_out == 100 every clk after about 6*R cycles, no ripple.
- Impulse: single transfer data_in=1 then zeros, gain=52 (s=0) -> i5 traces the (boxcar R)^5 response: values 1, 5, 15, 35, 70, ... at integrator output, summing to 16^5 over the response; returns to 0.
- Underrun: deassert data_in_valid for one load slot -> underrun pulses exactly 1 cycle on that load edge; comb input is zero for that slot; no ready stall.
- Saturation (macro defined): data_in=2047 constant, gain=40 -> data_out clamps to 2047. Same stimulus with macro undefined -> wrapped low bits.
- Reset mid-stream: assert arst during steady DC=100 -> data_out, data_in_ready, sample_clk, underrun go 0 immediately. After release, the DC test reproduces identically.
